pool_window_buffer: RTL and testbench

POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

---
 rtl/pool_window_buffer.sv | 183 ++++++++++++++++++
 tb/tb_pool_window_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// ---------------------------------------------------------------------------
// pool_window_buffer
//
// Purpose: turns a raster-order feature-map pixel stream into non-overlapping
// 2x2 windows with stride 2 for a downstream pooling stage. Even rows are kept
// in a one-row line buffer. On odd rows the even-column pixel is held and the
// window is completed by the odd-column pixel. The module has a single output
// slot. Pixel bits are passed through without change.
//
// Optional feature: define POOL_AVG_OUT_EN to add the pool_avg output. It is
// the registered average of the four window pixels.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   in_pixel   - raster-order input pixel (signed Q5.11)
//   in_valid   - in_pixel valid
//   in_ready   - block accepts in_pixel this cycle
//   win_00..11 - 2x2 window, [row][col]
//   win_valid  - window outputs valid
//   win_ready  - downstream accepts window
//   win_last   - high with the final window of a frame
//   pool_avg   - (POOL_AVG_OUT_EN only) floor(sum/4) of the window
// ---------------------------------------------------------------------------
module pool_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_pixel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] win_00,
    output logic signed [DATA_W-1:0] win_01,
    output logic signed [DATA_W-1:0] win_10,
    output logic signed [DATA_W-1:0] win_11,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     win_last
`ifdef POOL_AVG_OUT_EN
    ,
    output logic signed [DATA_W-1:0] pool_avg
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] w00_q, w00_d, w01_q, w01_d, w10_q, w10_d, w11_q, w11_d;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic [DATA_W-1:0] linebuf_q [IMG_W];

    logic              accept;
    logic              load;
    logic              col_last;
    logic              row_last;
    logic [COL_W-1:0]  left_col;
    logic [DATA_W-1:0] top_left;
    logic [DATA_W-1:0] top_right;

    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    // A window completes on an odd row at an odd column.
    assign load     = accept && row_q[0] && col_q[0];
    // The column is odd at load time, so clearing bit 0 gives col-1.
    assign left_col  = col_q ^ COL_W'(1);
    assign top_left  = linebuf_q[left_col];
    assign top_right = linebuf_q[col_q];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        w00_d       = w00_q;
        w01_d       = w01_q;
        w10_d       = w10_q;
        w11_d       = w11_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                hold_d = in_pixel;
            end
        end

        // A load takes priority over clearing. A transfer and a load in the
        // same cycle therefore leave win_valid set with the new window.
        if (load) begin
            w00_d       = top_left;
            w01_d       = top_right;
            w10_d       = hold_q;
            w11_d       = in_pixel;
            win_valid_d = 1'b1;
            win_last_d  = row_last && col_last;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            w00_q       <= '0;
            w01_q       <= '0;
            w10_q       <= '0;
            w11_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            w00_q       <= w00_d;
            w01_q       <= w01_d;
            w10_q       <= w10_d;
            w11_q       <= w11_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    // The line buffer has no reset. Each entry is rewritten on an even row
    // before it is read on the following odd row.
    always_ff @(posedge clk) begin
        if (accept && !row_q[0]) begin
            linebuf_q[col_q] <= in_pixel;
        end
    end

    assign win_00    = w00_q;
    assign win_01    = w01_q;
    assign win_10    = w10_q;
    assign win_11    = w11_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

`ifdef POOL_AVG_OUT_EN
    logic [DATA_W-1:0] avg_q, avg_d;
    logic [DATA_W+1:0] sum;

    assign sum = {{2{top_left[DATA_W-1]}},  top_left}
               + {{2{top_right[DATA_W-1]}}, top_right}
               + {{2{hold_q[DATA_W-1]}},    hold_q}
               + {{2{in_pixel[DATA_W-1]}},  in_pixel};

    // An arithmetic shift right by 2, truncated to DATA_W, is sum[DATA_W+1:2].
    always_comb begin
        avg_d = avg_q;
        if (load) begin
            avg_d = sum[DATA_W+1:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign pool_avg = avg_q;
`endif

endmodule

// File: tb/tb_pool_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_pool_window_buffer
//
// Bench for pool_window_buffer configured as a 4x4 map. A frame-array model
// predicts every window. It also predicts when win_valid must be set. A literal
// table of window contents anchors the directed frames.
// ---------------------------------------------------------------------------
module tb_pool_window_buffer;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] in_pixel;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] win_00, win_01, win_10, win_11;
    logic                 win_valid;
    logic                 win_ready;
    logic                 win_last;
`ifdef POOL_AVG_OUT_EN
    logic signed [DW-1:0] pool_avg;
`endif

    pool_window_buffer #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_00    (win_00),
        .win_01    (win_01),
        .win_10    (win_10),
        .win_11    (win_11),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last)
`ifdef POOL_AVG_OUT_EN
        ,
        .pool_avg  (pool_avg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        logic          last;
    } win_t;

    int checks   = 0;
    int failures = 0;

    // Model state. It is written only by the monitor.
    win_t          exp_q[$];
    logic [DW-1:0] frame [H][W];
    int            pos = 0;
    int            xfer_cnt = 0;
    bit            prev_hold = 0;
    win_t          prev_w;
    logic [DW-1:0] prev_avg;

    // Phase control. It is written only by the main process.
    int  lit_mode  = 0;   // 0 none, 1 frame table, 2 average literals
    int  lit_b[2]  = '{0, 0};
    int  lit_start = 0;
    bit  cnt_req   = 0;
    int  cnt_exp   = 0;
    int  tmo       = 0;
    int  rmode     = 0;   // 0 always ready, 1 random, 2 five-cycle stall
    int  stall_left = 0;
    bit  stall_done = 0;

    int off [4][4] = '{'{1, 2, 5, 6}, '{3, 4, 7, 8}, '{9, 10, 13, 14}, '{11, 12, 15, 16}};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] avg4(input win_t w);
        int s;
        s = int'($signed(w.a)) + int'($signed(w.b)) + int'($signed(w.c)) + int'($signed(w.d));
        s = s >>> 2;
        return DW'(s);
    endfunction

    // Monitor. At the falling edge it sees exactly what the next rising edge
    // will sample.
    always @(negedge clk) begin
        win_t w;
        int   r, c, k, f, i, base;
        if (rst) begin
            chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
            chk("rst_win_valid", {31'b0, win_valid}, 32'd0);
            chk("rst_win_last",  {31'b0, win_last},  32'd0);
            chk("rst_win_00", {16'b0, win_00}, 32'd0);
            chk("rst_win_01", {16'b0, win_01}, 32'd0);
            chk("rst_win_10", {16'b0, win_10}, 32'd0);
            chk("rst_win_11", {16'b0, win_11}, 32'd0);
`ifdef POOL_AVG_OUT_EN
            chk("rst_pool_avg", {16'b0, pool_avg}, 32'd0);
`endif
            exp_q.delete();
            pos = 0;
            prev_hold = 0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!win_valid || win_ready)});
            chk("win_valid", {31'b0, win_valid}, {31'b0, (exp_q.size() != 0)});
            if (!win_valid) chk("win_last_idle", {31'b0, win_last}, 32'd0);
            if (prev_hold) begin
                chk("hold_00", {16'b0, win_00}, {16'b0, prev_w.a});
                chk("hold_01", {16'b0, win_01}, {16'b0, prev_w.b});
                chk("hold_10", {16'b0, win_10}, {16'b0, prev_w.c});
                chk("hold_11", {16'b0, win_11}, {16'b0, prev_w.d});
                chk("hold_last", {31'b0, win_last}, {31'b0, prev_w.last});
`ifdef POOL_AVG_OUT_EN
                chk("hold_avg", {16'b0, pool_avg}, {16'b0, prev_avg});
`endif
            end
            if (win_valid && win_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("win_00", {16'b0, win_00}, {16'b0, w.a});
                chk("win_01", {16'b0, win_01}, {16'b0, w.b});
                chk("win_10", {16'b0, win_10}, {16'b0, w.c});
                chk("win_11", {16'b0, win_11}, {16'b0, w.d});
                chk("win_last", {31'b0, win_last}, {31'b0, w.last});
`ifdef POOL_AVG_OUT_EN
                chk("pool_avg", {16'b0, pool_avg}, {16'b0, avg4(w)});
`endif
                k = xfer_cnt - lit_start;
                if (lit_mode == 1) begin
                    f = k / 4;
                    i = k % 4;
                    base = (f < 2) ? lit_b[f] : 0;
                    chk("lit_00", {16'b0, win_00}, 32'(base + off[i][0]));
                    chk("lit_01", {16'b0, win_01}, 32'(base + off[i][1]));
                    chk("lit_10", {16'b0, win_10}, 32'(base + off[i][2]));
                    chk("lit_11", {16'b0, win_11}, 32'(base + off[i][3]));
                    chk("lit_last", {31'b0, win_last}, {31'b0, (i == 3)});
                end
`ifdef POOL_AVG_OUT_EN
                if (lit_mode == 2 && k == 0) chk("lit_avg0", {16'b0, pool_avg}, 32'h0800);
                if (lit_mode == 2 && k == 1) chk("lit_avg1", {16'b0, pool_avg}, 32'hFFFE);
`endif
                xfer_cnt++;
            end
            if (in_valid && in_ready) begin
                r = pos / W;
                c = pos % W;
                frame[r][c] = in_pixel;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    w.a = frame[r-1][c-1];
                    w.b = frame[r-1][c];
                    w.c = frame[r][c-1];
                    w.d = in_pixel;
                    w.last = (pos == W*H - 1);
                    exp_q.push_back(w);
                end
                pos = (pos + 1) % (W*H);
            end
            prev_hold = win_valid && !win_ready;
            prev_w = '{a: win_00, b: win_01, c: win_10, d: win_11, last: win_last};
`ifdef POOL_AVG_OUT_EN
            prev_avg = pool_avg;
`endif
            if (cnt_req) begin
                chk("window_count", 32'(xfer_cnt - lit_start), 32'(cnt_exp));
                chk("drained", 32'(exp_q.size()), 32'd0);
                chk("no_timeout", 32'(tmo), 32'd0);
            end
        end
    end

    // Downstream ready generator
    always @(posedge clk) begin
        #1;
        if (rmode != 2) stall_done = 0;
        case (rmode)
            1: win_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (!stall_done && win_valid) begin
                    stall_left = 5;
                    stall_done = 1;
                end
                win_ready = (stall_left == 0);
                if (stall_left != 0) stall_left--;
            end
            default: win_ready = 1'b1;
        endcase
    end

    task automatic send_pixel(input logic [DW-1:0] p, input bit gappy);
        int unsigned n;
        if (gappy) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = p;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) tmo++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic begin_phase(input int mode, input int b0, input int b1);
        lit_mode = 0;
        @(posedge clk); #1;
        lit_b[0]  = b0;
        lit_b[1]  = b1;
        lit_start = xfer_cnt;
        lit_mode  = mode;
    endtask

    task automatic end_phase(input int expn);
        int unsigned n;
        n = 0;
        while (win_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        cnt_exp = expn;
        cnt_req = 1;
        @(posedge clk); #1;
        cnt_req  = 0;
        lit_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single frame, always ready
        begin_phase(1, 0, 0);
        for (int p = 1; p <= 16; p++) send_pixel(DW'(p), 0);
        end_phase(4);

        // First window stalled for five cycles
        rmode = 2;
        begin_phase(1, 0, 0);
        for (int p = 1; p <= 16; p++) send_pixel(DW'(p), 0);
        end_phase(4);
        rmode = 0;

        // Two frames back-to-back
        begin_phase(1, 0, 100);
        for (int p = 1; p <= 16; p++) send_pixel(DW'(p), 0);
        for (int p = 101; p <= 116; p++) send_pixel(DW'(p), 0);
        end_phase(8);

        // Reset in the middle of a frame
        for (int p = 1; p <= 7; p++) send_pixel(DW'(p), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        begin_phase(1, 0, 0);
        for (int p = 1; p <= 16; p++) send_pixel(DW'(p), 0);
        end_phase(4);

`ifdef POOL_AVG_OUT_EN
        begin
            logic [DW-1:0] avf [16];
            for (int j = 0; j < 16; j++) avf[j] = '0;
            avf[0] = 16'h0800; avf[1] = 16'h0800; avf[4] = 16'h0800; avf[5] = 16'h0800;
            avf[2] = 16'hFFFF; avf[3] = 16'hFFFF; avf[6] = 16'hFFFF; avf[7] = 16'hFFFE;
            begin_phase(2, 0, 0);
            for (int j = 0; j < 16; j++) send_pixel(avf[j], 0);
            end_phase(4);
        end
`endif

        // Random pixels with random input gaps and random downstream stalls
        rmode = 1;
        begin_phase(0, 0, 0);
        for (int fr = 0; fr < 40; fr++) begin
            for (int j = 0; j < W*H; j++) send_pixel(DW'($urandom), 1);
        end
        end_phase(40 * (W/2) * (H/2));
        rmode = 0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
